// File: rtl/logic_arbiter.sv
// -----------------------------------------------------------------------------
// logic_arbiter
//
// Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two
// requesters. One requester is granted per transaction. Its operands are latched,
// the function is evaluated in one registered step, and the tagged result is
// held on a valid/ready output port until the consumer takes it.
//
// Handshake rule (all three ports): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds its payload stable while
// valid=1 and ready=0. Here reqN_ready depends only on state, rr and the two
// valids. res_valid depends only on state.
//
// Configuration macro:
//   LOGIC_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins a tie and
//                             no round-robin pointer exists. Default (undefined)
//                             is round-robin.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    requester N handshake (N = 0, 1)
//   reqN_op                    00 AND, 01 OR, 10 XOR, 11 NOR
//   reqN_x, reqN_y             operands, [0:WIDTH-1], bit 0 is MSB
//   res_valid / res_ready      result handshake
//   res_data                   bitwise result, [0:WIDTH-1]
//   res_id                     requester that issued the result
//   busy                       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module logic_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [0:WIDTH-1] req0_x,
  input  logic [0:WIDTH-1] req0_y,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [0:WIDTH-1] req1_x,
  input  logic [0:WIDTH-1] req1_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [0:WIDTH-1] res_data,
  output logic             res_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             grant0;
  logic             grant1;
  logic             grant_any;

  logic [1:0]       op_q;
  logic [0:WIDTH-1] x_q;
  logic [0:WIDTH-1] y_q;
  logic             id_q;
  logic [0:WIDTH-1] func_z;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  // Round-robin pointer: names the requester that wins the next tie.
  logic rr;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are only issued in IDLE, and at most one is issued.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        grant0 = ~rr;
        grant1 = rr;
`endif
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign grant_any  = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = HOLD;
      HOLD:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);

`ifndef LOGIC_ARB_FIXED_PRIO_EN
  // The pointer moves only on a grant. It points away from the requester just
  // served, so a lone requester keeps winning.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (grant_any) begin
      rr <= ~grant1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Operand capture on the granting edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 2'b00;
      x_q  <= '0;
      y_q  <= '0;
      id_q <= 1'b0;
    end else if (grant_any) begin
      op_q <= grant1 ? req1_op : req0_op;
      x_q  <= grant1 ? req1_x  : req0_x;
      y_q  <= grant1 ? req1_y  : req0_y;
      id_q <= grant1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bitwise function. It is purely per-bit: no carries, no cross-bit terms.
  // ---------------------------------------------------------------------------
  always_comb begin
    func_z = '0;
    case (op_q)
      2'b00:   func_z = x_q & y_q;
      2'b01:   func_z = x_q | y_q;
      2'b10:   func_z = x_q ^ y_q;
      default: func_z = ~(x_q | y_q);
    endcase
  end

  // Result registers load only in EXEC, so they stay stable for all of HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      res_id   <= 1'b0;
    end else if (state == EXEC) begin
      res_data <= func_z;
      res_id   <= id_q;
    end
  end

endmodule

// File: tb/tb_logic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_arbiter
//
// Self-checking bench for logic_arbiter. A transaction-level reference model
// tracks how long ago the last grant was, holds the round-robin preference, and
// keeps a queue of expected {id, data} results. The result is computed from a
// per-bit truth table. Directed scenarios are followed by randomized traffic.
// Inputs change 1 time unit after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_logic_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [0:WIDTH-1] req0_x, req0_y;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [0:WIDTH-1] req1_x, req1_y;
  logic             res_valid, res_ready;
  logic [0:WIDTH-1] res_data;
  logic             res_id, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // ---------------------------------------------------------------------------
  // Clock / reset block
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  logic_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_id     (res_id),
    .busy       (busy)
  );

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int             m_since;      // 0: free, 1: one cycle after grant, 2+: presenting
  logic           m_pref1;      // tie goes to requester 1 when set
  logic           m_rdy0, m_rdy1;
  logic           g0, g1;       // model grants seen in the last cycle
  logic [WIDTH:0] exp_q[$];     // {id, data}
  logic [WIDTH:0] xfer_log[$];  // observed DUT transfers
  int             grant_log[$]; // observed DUT grant ids
  int             gcyc_log[$];  // cycle numbers of those grants

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Truth table per op, indexed by {x_bit, y_bit}.
  function automatic logic [WIDTH-1:0] ref_logic(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
    logic [3:0]       lut;
    logic [WIDTH-1:0] z;
    case (op)
      2'd0:    lut = 4'b1000;
      2'd1:    lut = 4'b1110;
      2'd2:    lut = 4'b0110;
      default: lut = 4'b0001;
    endcase
    for (int i = 0; i < WIDTH; i++) z[i] = lut[{x[i], y[i]}];
    return z;
  endfunction

  function automatic void model_reset();
    m_since = 0;
    m_pref1 = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void predict();
    m_rdy0 = 1'b0;
    m_rdy1 = 1'b0;
    if (rst_n && m_since == 0) begin
      if (req0_valid && req1_valid) begin
`ifdef LOGIC_ARB_FIXED_PRIO_EN
        m_rdy0 = 1'b1;
`else
        m_rdy0 = ~m_pref1;
        m_rdy1 = m_pref1;
`endif
      end else begin
        m_rdy0 = req0_valid;
        m_rdy1 = req1_valid;
      end
    end
  endfunction

  function automatic void clear_logs();
    xfer_log.delete();
    grant_log.delete();
    gcyc_log.delete();
  endfunction

  // One clock cycle: compare at negedge, advance the model at posedge.
  task automatic cycle();
    @(negedge clk);
    predict();
    check("req0_ready", 64'(req0_ready), 64'(m_rdy0));
    check("req1_ready", 64'(req1_ready), 64'(m_rdy1));
    check("busy", 64'(busy), 64'(m_since != 0));
    check("res_valid", 64'(res_valid), 64'(m_since == 2));
    if (m_since == 2 && exp_q.size() != 0) begin
      check("res_data", 64'(res_data), 64'(exp_q[0][WIDTH-1:0]));
      check("res_id", 64'(res_id), 64'(exp_q[0][WIDTH]));
    end
    g0 = m_rdy0;
    g1 = m_rdy1;
    if (req0_valid && req0_ready) begin grant_log.push_back(0); gcyc_log.push_back(cyc); end
    if (req1_valid && req1_ready) begin grant_log.push_back(1); gcyc_log.push_back(cyc); end
    if (res_valid && res_ready) xfer_log.push_back({res_id, res_data});
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (m_since == 2) begin
      if (res_ready) begin
        m_since = 0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end else if (m_since == 1) begin
      m_since = 2;
    end else if (m_rdy0 || m_rdy1) begin
      if (m_rdy1) exp_q.push_back({1'b1, ref_logic(req1_op, req1_x, req1_y)});
      else        exp_q.push_back({1'b0, ref_logic(req0_op, req0_x, req0_y)});
      m_pref1 = m_rdy0;
      m_since = 1;
    end
    cyc++;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_req(input int n, input logic [1:0] op,
                           input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (n == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_x = x; req0_y = y;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_x = x; req1_y = y;
    end
  endtask

  task automatic renew(input int n);
    drive_req(n, 2'($urandom_range(0, 3)), $urandom(), $urandom());
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int exp_c[4];
  logic [WIDTH-1:0] t2_exp[4];

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_x = '0; req0_y = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_x = '0; req1_y = '0;
    res_ready = 1'b0;
    model_reset();
    repeat (2) cycle();
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Single request: req0 OR
    clear_logs();
    res_ready = 1'b1;
    drive_req(0, 2'b01, 32'hF0F0_0000, 32'h0F0F_0001);
    cycle();
    req0_valid = 1'b0;
    repeat (3) cycle();
    check("t1_count", 64'(xfer_log.size()), 64'd1);
    if (xfer_log.size() > 0) check("t1_result", 64'(xfer_log[0]), 64'({1'b0, 32'hFFFF_0001}));

    // All ops on requester 1
    clear_logs();
    t2_exp = '{32'hAAAA_0000, 32'hFFFF_AAAA, 32'h5555_AAAA, 32'h0000_5555};
    for (int op = 0; op < 4; op++) begin
      drive_req(1, 2'(op), 32'hAAAA_AAAA, 32'hFFFF_0000);
      cycle();
      req1_valid = 1'b0;
      repeat (2) cycle();
    end
    check("t2_count", 64'(xfer_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < xfer_log.size(); i++)
      check("t2_result", 64'(xfer_log[i]), 64'({1'b1, t2_exp[i]}));

    // Contention after reset
    do_reset();
    clear_logs();
    res_ready = 1'b1;
    renew(0);
    renew(1);
    repeat (12) begin
      cycle();
      if (g0) renew(0);
      if (g1) renew(1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) cycle();
`ifdef LOGIC_ARB_FIXED_PRIO_EN
    exp_c = '{0, 0, 0, 0};
`else
    exp_c = '{0, 1, 0, 1};
`endif
    check("t3_grants", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("t3_grant_id", 64'(grant_log[i]), 64'(exp_c[i]));

    // Backpressure: res_ready low for 5 HOLD cycles, req1 waiting
    clear_logs();
    res_ready = 1'b0;
    drive_req(0, 2'b00, 32'h1234_5678, 32'h0FF0_F00F);
    cycle();
    req0_valid = 1'b0;
    renew(1);
    cycle();
    repeat (5) cycle();
    res_ready = 1'b1;
    cycle();
    cycle();
    req1_valid = 1'b0;
    repeat (2) cycle();
    check("t4_xfers", 64'(xfer_log.size()), 64'd2);
    check("t4_grants", 64'(grant_log.size()), 64'd2);
    if (xfer_log.size() > 0)
      check("t4_result", 64'(xfer_log[0]), 64'({1'b0, 32'h0230_5008}));
    if (gcyc_log.size() > 1)
      check("t4_regrant_gap", 64'(gcyc_log[1] - gcyc_log[0]), 64'd8);

    // Reset during EXEC
    clear_logs();
    res_ready = 1'b1;
    drive_req(0, 2'b10, $urandom(), $urandom());
    cycle();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_res_valid", 64'(res_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_res_data", 64'(res_data), 64'd0);
    check("t5_res_id", 64'(res_id), 64'd0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("t5_no_result", 64'(xfer_log.size()), 64'd0);
    drive_req(1, 2'b11, 32'h8000_0001, 32'h0000_00FF);
    cycle();
    req1_valid = 1'b0;
    repeat (3) cycle();
    check("t5_after_count", 64'(xfer_log.size()), 64'd1);
    if (xfer_log.size() > 0)
      check("t5_after_result", 64'(xfer_log[0]), 64'({1'b1, 32'h7FFF_FF00}));

    // Lone requester 1
    do_reset();
    clear_logs();
    res_ready = 1'b1;
    renew(1);
    repeat (9) begin
      cycle();
      if (g1) renew(1);
    end
    req1_valid = 1'b0;
    repeat (3) cycle();
    check("t6_grants", 64'(grant_log.size()), 64'd3);
    for (int i = 0; i < grant_log.size(); i++) check("t6_grant_id", 64'(grant_log[i]), 64'd1);
    for (int i = 1; i < gcyc_log.size(); i++)
      check("t6_grant_gap", 64'(gcyc_log[i] - gcyc_log[i-1]), 64'd3);
`ifndef LOGIC_ARB_FIXED_PRIO_EN
    check("t6_rr", 64'(dut.rr), 64'd0);
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!req0_valid || g0) begin
        if ($urandom_range(0, 2) != 0) renew(0); else req0_valid = 1'b0;
      end
      if (!req1_valid || g1) begin
        if ($urandom_range(0, 2) != 0) renew(1); else req1_valid = 1'b0;
      end
      res_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    repeat (4) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
